// File: rtl/tg_pkg.sv
// Shared types for the PE traffic generator: packet layout, FSM states, LFSR taps.
// Node count comes from the global `NODES macro (defaults to 16 when not set).
`ifndef NODES
`define NODES 16
`endif

package tg_pkg;

  localparam int TG_NODES = `NODES;
  localparam int DEST_W   = (TG_NODES > 1) ? $clog2(TG_NODES) : 1;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tg_state_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DEST_W-1:0] src;
    logic [15:0]       seq;
    logic [15:0]       ts;
  } packet_t;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tg_fifo.sv
// Synchronous packet FIFO with a registered head word and registered full flag.
// The head register is loaded with the element that will be at the read pointer
// after this edge, so an empty->push shows valid data one cycle later and the
// head stays stable while no pop occurs.
module tg_fifo
  import tg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_push,
  input  packet_t i_data,
  input  logic    i_pop,
  output packet_t o_head,
  output logic    o_head_val,
  output logic    o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  packet_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  packet_t       r_head;
  logic          r_head_val;
  logic          r_full;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;
  packet_t       w_head_next;

  // A full FIFO refuses the push even if the head is popped in the same cycle
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && r_head_val;

  // Next occupancy, next read pointer and the word that becomes the head
  always_comb begin
    w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
    w_count_next  = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
    if (w_count_next == '0) begin
      w_head_next = '0;
    end else if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_next = i_data;
    end else begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  // Storage write; contents are only read at valid positions, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy, flags and head register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_head_val <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr   <= w_rd_ptr_next;
      r_count    <= w_count_next;
      r_head     <= w_head_next;
      r_head_val <= (w_count_next != '0);
      r_full     <= (w_count_next == CW'(DEPTH));
    end
  end

  assign o_head     = r_head;
  assign o_head_val = r_head_val;
  assign o_full     = r_full;

endmodule

// File: rtl/pe_traffic_gen.sv
// Per-node packet source for one PE injection port of the network.
// Generates PKT_LIMIT packets at one per RATE_PERIOD cycles with LFSR-chosen
// destinations, queues them in tg_fifo and injects on o_data_val && i_en.
// Optional build macro TG_TIMESTAMP_EN: stamps packets with a free-running
// 16-bit cycle counter; without it the ts field is zero.
module pe_traffic_gen
  import tg_pkg::*;
#(
  parameter int          NODE_ID     = 0,
  parameter int          NODES       = 16,
  parameter int          PKT_LIMIT   = 64,
  parameter int          RATE_PERIOD = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_en,
  output packet_t     o_data,
  output logic        o_data_val,
  output logic [15:0] o_sent_cnt,
  output logic [15:0] o_drop_cnt,
  output logic        o_busy,
  output logic        o_done
);

  localparam int RC_W = (RATE_PERIOD > 1) ? $clog2(RATE_PERIOD) : 1;

  tg_state_t     r_state;
  tg_state_t     w_state_next;
  logic          w_start_run;
  logic [RC_W-1:0] r_rate_cnt;
  logic [15:0]   r_gen_cnt;
  logic [15:0]   r_sent_cnt;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_lfsr;
  logic [15:0]   w_lfsr_next;
  logic          w_tick;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_val;
  int            w_dest_int;
  logic [15:0]   w_ts;
  packet_t       w_pkt;

  assign w_tick      = (r_state == RUN) && (r_rate_cnt == RC_W'(RATE_PERIOD - 1));
  assign w_pop       = w_fifo_val && i_en;
  assign w_lfsr_next = lfsr_step(r_lfsr);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; i_start only matters in IDLE and DONE
  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state_next = RUN;
          w_start_run  = 1'b1;
        end
      end
      RUN: begin
        if (w_tick && (r_gen_cnt == 16'(PKT_LIMIT - 1))) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_fifo_val) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Rate counter runs only in RUN and restarts on every run entry
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_rate_cnt <= '0;
    end else if (r_state == RUN) begin
      r_rate_cnt <= w_tick ? '0 : r_rate_cnt + RC_W'(1);
    end
  end

  // Generated count doubles as the packet sequence number
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_gen_cnt <= '0;
    end else if (w_tick) begin
      r_gen_cnt <= r_gen_cnt + 16'd1;
    end
  end

  // LFSR reseeds only on reset, so a restart continues the sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_tick) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Sent count follows the network handshake
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_sent_cnt <= '0;
    end else if (w_pop) begin
      r_sent_cnt <= r_sent_cnt + 16'd1;
    end
  end

  // Drop count uses the registered full flag, matching the FIFO's push refusal
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_drop_cnt <= '0;
    end else if (w_tick && w_fifo_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Destination from the stepped LFSR, skipping this node itself
  always_comb begin
    w_dest_int = int'(w_lfsr_next[DEST_W-1:0]) % NODES;
    if (w_dest_int == NODE_ID) begin
      w_dest_int = (w_dest_int + 1) % NODES;
    end
  end

`ifdef TG_TIMESTAMP_EN
  logic [15:0] r_cycle_cnt;

  // Free-running timestamp source
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign w_ts = r_cycle_cnt;
`else
  assign w_ts = '0;
`endif

  assign w_pkt.dest = DEST_W'(w_dest_int);
  assign w_pkt.src  = DEST_W'(NODE_ID);
  assign w_pkt.seq  = r_gen_cnt;
  assign w_pkt.ts   = w_ts;

  tg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_tick),
    .i_data     (w_pkt),
    .i_pop      (w_pop),
    .o_head     (o_data),
    .o_head_val (w_fifo_val),
    .o_full     (w_fifo_full)
  );

  assign o_data_val = w_fifo_val;
  assign o_sent_cnt = r_sent_cnt;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = (r_state == RUN) || (r_state == DRAIN);
  assign o_done     = (r_state == DONE);

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Directed testbench for pe_traffic_gen.
// dut_a: NODE_ID=3, RATE_PERIOD=4, PKT_LIMIT=8 (basic run, restart, mid-run reset).
// dut_b: NODE_ID=0, RATE_PERIOD=2, PKT_LIMIT=20, FIFO_DEPTH=4 (backpressure, pop on full).
module tb_pe_traffic_gen;
  import tg_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        start_a = 1'b0, en_a = 1'b0;
  packet_t     data_a;
  logic        val_a, busy_a, done_a;
  logic [15:0] sent_a, drop_a;

  logic        start_b = 1'b0, en_b = 1'b0;
  packet_t     data_b;
  logic        val_b, busy_b, done_b;
  logic [15:0] sent_b, drop_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Destinations hand-derived from seed 16'hACE1 for NODE_ID=3 (3 remaps to 4)
  int exp_dest [8] = '{4, 7, 15, 14, 12, 9, 2, 4};

  packet_t cap_pk [32];
  int      cap_n;

  always #5 clk = ~clk;

  pe_traffic_gen #(
    .NODE_ID(3), .NODES(16), .PKT_LIMIT(8), .RATE_PERIOD(4), .FIFO_DEPTH(4), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_en(en_a),
    .o_data(data_a), .o_data_val(val_a), .o_sent_cnt(sent_a), .o_drop_cnt(drop_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  pe_traffic_gen #(
    .NODE_ID(0), .NODES(16), .PKT_LIMIT(20), .RATE_PERIOD(2), .FIFO_DEPTH(4), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_en(en_b),
    .o_data(data_b), .o_data_val(val_b), .o_sent_cnt(sent_b), .o_drop_cnt(drop_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
  endtask

  // Capture accepted dut_a packets until done or stop_n captured (bounded)
  task automatic collect_a(input int stop_n, output bit timed_out);
    int cyc;
    cyc = 0;
    cap_n = 0;
    timed_out = 1'b0;
    forever begin
      if (val_a && en_a && cap_n < 32) begin
        cap_pk[cap_n] = data_a;
        cap_n++;
      end
      if (done_a || cap_n >= stop_n) break;
      if (cyc >= 300) begin
        timed_out = 1'b1;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_tests++; if (val_a !== 1'b0 || val_b !== 1'b0) begin n_fail++; $display("FAIL reset_val: got a=%0b b=%0b expected 0", val_a, val_b); end
    n_tests++; if (data_a !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_a); end
    n_tests++; if (sent_a !== 16'd0 || drop_a !== 16'd0 || sent_b !== 16'd0 || drop_b !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d %0d %0d %0d expected 0", sent_a, drop_a, sent_b, drop_b); end
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL reset_state: got busy=%0b done=%0b expected 0 0", busy_a, done_a); end
    $display("[TB] reset: val=%0b sent=%0d drop=%0d busy=%0b done=%0b", val_a, sent_a, drop_a, busy_a, done_a);
  endtask

  task automatic test_basic();
    bit to;
    en_a = 1'b1;
    pulse_start_a();
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b expected 1", busy_a); end
    collect_a(32, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
    n_tests++; if (cap_n !== 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", cap_n); end
    for (int i = 0; i < cap_n && i < 8; i++) begin
      $display("[TB] basic pkt %0d: dest=%0d src=%0d seq=%0d ts=%0d", i, cap_pk[i].dest, cap_pk[i].src, cap_pk[i].seq, cap_pk[i].ts);
      n_tests++; if (cap_pk[i].seq !== 16'(i)) begin n_fail++; $display("FAIL basic_seq%0d: got %0d expected %0d", i, cap_pk[i].seq, i); end
      n_tests++; if (int'(cap_pk[i].src) !== 3) begin n_fail++; $display("FAIL basic_src%0d: got %0d expected 3", i, cap_pk[i].src); end
      n_tests++; if (int'(cap_pk[i].dest) !== exp_dest[i]) begin n_fail++; $display("FAIL basic_dest%0d: got %0d expected %0d", i, cap_pk[i].dest, exp_dest[i]); end
`ifdef TG_TIMESTAMP_EN
      if (i > 0) begin
        n_tests++; if (16'(cap_pk[i].ts - cap_pk[i-1].ts) !== 16'd4) begin n_fail++; $display("FAIL basic_ts%0d: got delta %0d expected 4", i, 16'(cap_pk[i].ts - cap_pk[i-1].ts)); end
      end
`else
      n_tests++; if (cap_pk[i].ts !== 16'd0) begin n_fail++; $display("FAIL basic_ts%0d: got %0d expected 0", i, cap_pk[i].ts); end
`endif
    end
    n_tests++; if (sent_a !== 16'd8 || drop_a !== 16'd0) begin n_fail++; $display("FAIL basic_cnt: got sent=%0d drop=%0d expected 8 0", sent_a, drop_a); end
    n_tests++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%0b busy=%0b expected 1 0", done_a, busy_a); end
  endtask

  task automatic test_restart();
    bit to;
    int ndiff;
    pulse_start_a();
    n_tests++; if (sent_a !== 16'd0 || busy_a !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got sent=%0d busy=%0b done=%0b expected 0 1 0", sent_a, busy_a, done_a); end
    collect_a(32, to);
    n_tests++; if (to || cap_n !== 8) begin n_fail++; $display("FAIL restart_count: got %0d timeout=%0b expected 8", cap_n, to); end
    ndiff = 0;
    for (int i = 0; i < cap_n && i < 8; i++) begin
      $display("[TB] restart pkt %0d: dest=%0d seq=%0d", i, cap_pk[i].dest, cap_pk[i].seq);
      n_tests++; if (cap_pk[i].seq !== 16'(i)) begin n_fail++; $display("FAIL restart_seq%0d: got %0d expected %0d", i, cap_pk[i].seq, i); end
      n_tests++; if (int'(cap_pk[i].dest) == 3) begin n_fail++; $display("FAIL restart_self%0d: got dest %0d expected not 3", i, cap_pk[i].dest); end
      if (int'(cap_pk[i].dest) != exp_dest[i]) ndiff++;
    end
    n_tests++; if (int'(cap_pk[0].dest) !== 8) begin n_fail++; $display("FAIL restart_dest0: got %0d expected 8", cap_pk[0].dest); end
    n_tests++; if (ndiff == 0) begin n_fail++; $display("FAIL restart_lfsr: got %0d differing dests expected >0", ndiff); end
    n_tests++; if (sent_a !== 16'd8 || done_a !== 1'b1) begin n_fail++; $display("FAIL restart_end: got sent=%0d done=%0b expected 8 1", sent_a, done_a); end
  endtask

  task automatic test_reset_midrun();
    bit to;
    pulse_start_a();
    collect_a(3, to);
    n_tests++; if (to || cap_n !== 3) begin n_fail++; $display("FAIL midrun_pre: got %0d timeout=%0b expected 3", cap_n, to); end
    step();
    n_tests++; if (sent_a !== 16'd3) begin n_fail++; $display("FAIL midrun_sent3: got %0d expected 3", sent_a); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("[TB] midrun reset: val=%0b sent=%0d drop=%0d busy=%0b done=%0b", val_a, sent_a, drop_a, busy_a, done_a);
    n_tests++; if (val_a !== 1'b0 || data_a !== '0) begin n_fail++; $display("FAIL midrun_val: got val=%0b data=%h expected 0 0", val_a, data_a); end
    n_tests++; if (sent_a !== 16'd0 || drop_a !== 16'd0) begin n_fail++; $display("FAIL midrun_cnt: got sent=%0d drop=%0d expected 0 0", sent_a, drop_a); end
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: got busy=%0b done=%0b expected 0 0", busy_a, done_a); end
    pulse_start_a();
    collect_a(32, to);
    n_tests++; if (to || cap_n !== 8) begin n_fail++; $display("FAIL midrun_count: got %0d timeout=%0b expected 8", cap_n, to); end
    for (int i = 0; i < cap_n && i < 8; i++) begin
      n_tests++; if (int'(cap_pk[i].dest) !== exp_dest[i] || cap_pk[i].seq !== 16'(i)) begin n_fail++; $display("FAIL midrun_pkt%0d: got dest=%0d seq=%0d expected %0d %0d", i, cap_pk[i].dest, cap_pk[i].seq, exp_dest[i], i); end
    end
    n_tests++; if (sent_a !== 16'd8) begin n_fail++; $display("FAIL midrun_end: got sent=%0d expected 8", sent_a); end
  endtask

  task automatic test_backpressure();
    packet_t held;
    bit      have;
    int      n, cyc;
    en_b = 1'b0;
    have = 1'b0;
    held = '0;
    pulse_start_b();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (val_b) begin
        if (!have) begin
          held = data_b;
          have = 1'b1;
        end else begin
          n_tests++; if (data_b !== held) begin n_fail++; $display("FAIL bp_stable@%0d: got %h expected %h", k, data_b, held); end
        end
      end
    end
    $display("[TB] backpressure stall: val=%0b sent=%0d drop=%0d busy=%0b head_seq=%0d", val_b, sent_b, drop_b, busy_b, data_b.seq);
    n_tests++; if (!have || held.seq !== 16'd0 || held.src !== '0) begin n_fail++; $display("FAIL bp_head: got have=%0b seq=%0d src=%0d expected 1 0 0", have, held.seq, held.src); end
    n_tests++; if (drop_b !== 16'd16 || sent_b !== 16'd0) begin n_fail++; $display("FAIL bp_drop: got drop=%0d sent=%0d expected 16 0", drop_b, sent_b); end
    n_tests++; if (val_b !== 1'b1 || busy_b !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got val=%0b busy=%0b expected 1 1", val_b, busy_b); end
    en_b = 1'b1;
    n = 0;
    cyc = 0;
    while (!done_b && cyc < 100) begin
      if (val_b) begin
        n_tests++; if (data_b.seq !== 16'(n)) begin n_fail++; $display("FAIL bp_seq%0d: got %0d expected %0d", n, data_b.seq, n); end
        n++;
      end
      step();
      cyc++;
    end
    n_tests++; if (!done_b || n !== 4 || sent_b !== 16'd4) begin n_fail++; $display("FAIL bp_drain: got done=%0b n=%0d sent=%0d expected 1 4 4", done_b, n, sent_b); end
    $display("[TB] backpressure drain: sent=%0d drop=%0d done=%0b", sent_b, drop_b, done_b);
  endtask

  task automatic test_pop_on_full();
    int cyc;
    en_b = 1'b0;
    pulse_start_b();
    for (int k = 1; k <= 9; k++) step();
    n_tests++; if (drop_b !== 16'd0 || val_b !== 1'b1) begin n_fail++; $display("FAIL pof_pre: got drop=%0d val=%0b expected 0 1", drop_b, val_b); end
    en_b = 1'b1;
    step();
    en_b = 1'b0;
    $display("[TB] pop on full: sent=%0d drop=%0d head_seq=%0d", sent_b, drop_b, data_b.seq);
    n_tests++; if (drop_b !== 16'd1 || sent_b !== 16'd1) begin n_fail++; $display("FAIL pof_cnt: got drop=%0d sent=%0d expected 1 1", drop_b, sent_b); end
    n_tests++; if (data_b.seq !== 16'd1) begin n_fail++; $display("FAIL pof_head: got seq=%0d expected 1", data_b.seq); end
    step(); step();
    n_tests++; if (drop_b !== 16'd1) begin n_fail++; $display("FAIL pof_room: got drop=%0d expected 1", drop_b); end
    step(); step();
    n_tests++; if (drop_b !== 16'd2) begin n_fail++; $display("FAIL pof_refull: got drop=%0d expected 2", drop_b); end
    for (int k = 15; k <= 40; k++) step();
    n_tests++; if (drop_b !== 16'd15) begin n_fail++; $display("FAIL pof_drop_end: got %0d expected 15", drop_b); end
    en_b = 1'b1;
    cyc = 0;
    while (!done_b && cyc < 100) begin
      step();
      cyc++;
    end
    n_tests++; if (!done_b || sent_b !== 16'd5) begin n_fail++; $display("FAIL pof_end: got done=%0b sent=%0d expected 1 5", done_b, sent_b); end
    $display("[TB] pop on full end: sent=%0d drop=%0d done=%0b", sent_b, drop_b, done_b);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    test_reset();
    test_basic();
    test_restart();
    test_reset_midrun();
    test_backpressure();
    test_pop_on_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
